// File: rtl/bram_dp_arbiter.sv
// Round-robin arbiter sharing one dual-port block RAM among NREQ requesters,
// with an optional zero-fill sweep of the memory after reset.
module bram_dp_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 16,
    parameter int unsigned CLEAR = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    REQ_VALID,
    output logic [NREQ-1:0]    REQ_READY,
    input  logic [NREQ-1:0]    REQ_WE,
    input  logic [NREQ*AW-1:0] REQ_ADDR,
    input  logic [NREQ*DW-1:0] REQ_DATA,
    output logic [NREQ-1:0]    RSP_VALID,
    output logic [NREQ*DW-1:0] RSP_DATA,
    output logic               INIT_DONE,
    output logic [AW-1:0]      A0,
    output logic [AW-1:0]      A1,
    output logic [DW-1:0]      D0,
    output logic [DW-1:0]      D1,
    output logic               WE0,
    output logic               WE1,
    output logic               CE0,
    output logic               CE1,
    input  logic [DW-1:0]      Q0,
    input  logic [DW-1:0]      Q1
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = AW - 1;

    typedef enum logic {ST_CLR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] clr_cnt;
    logic [IW-1:0] rr_ptr;
    logic          tag0_v;
    logic          tag1_v;
    logic [IW-1:0] tag0_idx;
    logic [IW-1:0] tag1_idx;

    logic          gnt0_c;
    logic          gnt1_c;
    logic [IW-1:0] scan_idx_c;
    logic [IW-1:0] g0_idx_c;
    logic [IW-1:0] g1_idx_c;
    logic [AW-1:0] g0_addr_c;
    logic [AW-1:0] g1_addr_c;
    logic [DW-1:0] g0_data_c;
    logic [DW-1:0] g1_data_c;
    logic          g0_we_c;
    logic          g1_we_c;
    logic [IW-1:0] last_idx_c;
    logic [IW-1:0] ptr_next_c;

    // Scan from the round-robin pointer; the first two valid requesters win.
    always_comb begin : grant
        gnt0_c     = 1'b0;
        gnt1_c     = 1'b0;
        scan_idx_c = '0;
        g0_idx_c   = '0;
        g1_idx_c   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx_c = IW'((32'(rr_ptr) + k) % NREQ);
            if (REQ_VALID[scan_idx_c]) begin
                if (!gnt0_c) begin
                    gnt0_c   = 1'b1;
                    g0_idx_c = scan_idx_c;
                end else if (!gnt1_c) begin
                    gnt1_c   = 1'b1;
                    g1_idx_c = scan_idx_c;
                end
            end
        end
        g0_addr_c = REQ_ADDR[32'(g0_idx_c)*AW +: AW];
        g1_addr_c = REQ_ADDR[32'(g1_idx_c)*AW +: AW];
        g0_data_c = REQ_DATA[32'(g0_idx_c)*DW +: DW];
        g1_data_c = REQ_DATA[32'(g1_idx_c)*DW +: DW];
        g0_we_c   = REQ_WE[g0_idx_c];
        g1_we_c   = REQ_WE[g1_idx_c];
        // Same-address pair involving a write: the second winner waits a cycle.
        if (gnt1_c && (g0_addr_c == g1_addr_c) && (g0_we_c || g1_we_c)) begin
            gnt1_c = 1'b0;
        end
        last_idx_c = gnt1_c ? g1_idx_c : g0_idx_c;
        ptr_next_c = IW'((32'(last_idx_c) + 32'd1) % NREQ);
    end

    always_ff @(posedge CLK) begin : state_reg
        if (RST) begin
            state <= (CLEAR != 0) ? ST_CLR : ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin : next_state
        state_next = state;
        case (state)
            ST_CLR:  if (clr_cnt == {CW{1'b1}}) state_next = ST_RUN;
            default: state_next = state;
        endcase
    end

    // Sweep counter, round-robin pointer and per-port read tags.
    always_ff @(posedge CLK) begin : datapath
        if (RST) begin
            clr_cnt  <= '0;
            rr_ptr   <= '0;
            tag0_v   <= 1'b0;
            tag1_v   <= 1'b0;
            tag0_idx <= '0;
            tag1_idx <= '0;
        end else begin
            clr_cnt  <= (state == ST_CLR) ? clr_cnt + CW'(1) : '0;
            if ((state == ST_RUN) && gnt0_c) begin
                rr_ptr <= ptr_next_c;
            end
            tag0_v   <= (state == ST_RUN) && gnt0_c && !g0_we_c;
            tag1_v   <= (state == ST_RUN) && gnt1_c && !g1_we_c;
            tag0_idx <= g0_idx_c;
            tag1_idx <= g1_idx_c;
        end
    end

    always_comb begin : outputs
        REQ_READY = '0;
        RSP_VALID = '0;
        RSP_DATA  = '0;
        INIT_DONE = 1'b0;
        A0        = '0;
        A1        = '0;
        D0        = '0;
        D1        = '0;
        WE0       = 1'b0;
        WE1       = 1'b0;
        CE0       = 1'b0;
        CE1       = 1'b0;
        if (!RST) begin
            case (state)
                ST_CLR: begin
                    CE0 = 1'b1;
                    CE1 = 1'b1;
                    WE0 = 1'b1;
                    WE1 = 1'b1;
                    A0  = {clr_cnt, 1'b0};
                    A1  = {clr_cnt, 1'b1};
                end
                default: begin
                    INIT_DONE = 1'b1;
                    if (gnt0_c) begin
                        REQ_READY[g0_idx_c] = 1'b1;
                        CE0 = 1'b1;
                        WE0 = g0_we_c;
                        A0  = g0_addr_c;
                        D0  = g0_data_c;
                    end
                    if (gnt1_c) begin
                        REQ_READY[g1_idx_c] = 1'b1;
                        CE1 = 1'b1;
                        WE1 = g1_we_c;
                        A1  = g1_addr_c;
                        D1  = g1_data_c;
                    end
                    if (tag0_v) begin
                        RSP_VALID[tag0_idx] = 1'b1;
                        RSP_DATA[32'(tag0_idx)*DW +: DW] = Q0;
                    end
                    if (tag1_v) begin
                        RSP_VALID[tag1_idx] = 1'b1;
                        RSP_DATA[32'(tag1_idx)*DW +: DW] = Q1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_dp_arbiter.sv
// Randomized and directed bench for bram_dp_arbiter: a transaction-level model
// predicts grants, port drive and read data; a monitor scores read responses.
module tb_bram_dp_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 10;
    localparam int DW   = 16;
    localparam int NSWP = 512;

    logic               CLK = 1'b0;
    logic               RST;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ*DW-1:0] rsp_data;
    logic               init_done;
    logic [AW-1:0]      a0, a1;
    logic [DW-1:0]      d0, d1, q0, q1;
    logic               we0, we1, ce0, ce1;

    bram_dp_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CLEAR(1)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
        .REQ_ADDR(req_addr), .REQ_DATA(req_data),
        .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .INIT_DONE(init_done),
        .A0(a0), .A1(a1), .D0(d0), .D1(d1), .WE0(we0), .WE1(we1),
        .CE0(ce0), .CE1(ce1), .Q0(q0), .Q1(q1)
    );

    always #5 CLK = ~CLK;

    // Block RAM: registered read of the old contents, write on CE & WE.
    logic [DW-1:0] mem [1 << AW];
    initial begin
        q0 = '0;
        q1 = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    end
    always @(posedge CLK) begin
        if (ce0) begin
            q0 <= mem[a0];
            if (we0) mem[a0] <= d0;
        end
        if (ce1) begin
            q1 <= mem[a1];
            if (we1) mem[a1] <= d1;
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            m_p = 0;
    int            sweep_left = 0;
    logic [DW-1:0] shadow [1 << AW];
    rsp_t          exp_q [NREQ][$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return req_data[i*DW +: DW];
    endfunction

    // Reference model, evaluated once per cycle with inputs stable.
    int   cand[$];
    rsp_t r;
    always @(negedge CLK) begin : model
        int g0, g1, c;
        logic [NREQ-1:0] exp_ready;
        logic [AW+DW+1:0] exp_p0, exp_p1;
        if (RST) begin
            chk({req_ready, rsp_valid, ce0, ce1, we0, we1, init_done} == '0, "reset_outputs",
                {req_ready, rsp_valid, ce0, ce1, we0, we1, init_done}, 0);
            m_p = 0;
            sweep_left = NSWP;
            for (int i = 0; i < NREQ; i++) exp_q[i].delete();
            for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;
        end else if (sweep_left > 0) begin
            c = NSWP - sweep_left;
            chk(req_ready == '0 && !init_done && ce0 && ce1 && we0 && we1 &&
                a0 == AW'(2*c) && a1 == AW'(2*c+1) && d0 == '0 && d1 == '0,
                "sweep_drive", {init_done, req_ready, ce0, ce1, we0, we1, a0}, 2*c);
            sweep_left--;
        end else begin
            chk(init_done == 1'b1, "init_done", init_done, 1);
            cand.delete();
            for (int k = 0; k < NREQ; k++)
                if (req_valid[(m_p + k) % NREQ]) cand.push_back((m_p + k) % NREQ);
            g0 = (cand.size() > 0) ? cand[0] : -1;
            g1 = (cand.size() > 1) ? cand[1] : -1;
            if (g1 >= 0 && addr_of(g0) == addr_of(g1) && (req_we[g0] || req_we[g1])) g1 = -1;
            exp_ready = '0;
            exp_p0 = '0;
            exp_p1 = '0;
            if (g0 >= 0) begin
                exp_ready[g0] = 1'b1;
                exp_p0 = {1'b1, req_we[g0], addr_of(g0), data_of(g0)};
            end
            if (g1 >= 0) begin
                exp_ready[g1] = 1'b1;
                exp_p1 = {1'b1, req_we[g1], addr_of(g1), data_of(g1)};
            end
            chk(req_ready == exp_ready, "req_ready", req_ready, exp_ready);
            chk({ce0, we0, a0, d0} == exp_p0, "port0", {ce0, we0, a0, d0}, exp_p0);
            chk({ce1, we1, a1, d1} == exp_p1, "port1", {ce1, we1, a1, d1}, exp_p1);
            foreach (cand[j]) begin
                if ((cand[j] == g0 || cand[j] == g1) && !req_we[cand[j]]) begin
                    r.data = shadow[addr_of(cand[j])];
                    r.due  = cyc + 1;
                    exp_q[cand[j]].push_back(r);
                end
            end
            if (g0 >= 0 && req_we[g0]) shadow[addr_of(g0)] = data_of(g0);
            if (g1 >= 0 && req_we[g1]) shadow[addr_of(g1)] = data_of(g1);
            if (g1 >= 0) m_p = (g1 + 1) % NREQ;
            else if (g0 >= 0) m_p = (g0 + 1) % NREQ;
        end
    end

    // Response monitor: pops the expected read for each lane that fires.
    always @(negedge CLK) begin : monitor
        rsp_t e;
        logic [DW-1:0] lane;
        for (int i = 0; i < NREQ; i++) begin
            lane = rsp_data[i*DW +: DW];
            if (rsp_valid[i]) begin
                if (exp_q[i].size() == 0) begin
                    chk(1'b0, "rsp_unexpected", i, lane);
                end else begin
                    e = exp_q[i].pop_front();
                    chk(lane == e.data && e.due == cyc, "rsp_data",
                        {32'(cyc), lane}, {32'(e.due), e.data});
                end
            end else begin
                chk(lane == '0, "rsp_idle_lane", lane, 0);
                if (exp_q[i].size() > 0 && exp_q[i][0].due < cyc) begin
                    e = exp_q[i].pop_front();
                    chk(1'b0, "rsp_missing", i, e.due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic rand_req(input bit narrow);
        logic [AW-1:0] a;
        idle();
        for (int i = 0; i < NREQ; i++) begin
            if (narrow) a = (($urandom % 4) == 0) ? AW'(10'h3FF) : AW'($urandom_range(0, 7));
            else a = AW'($urandom);
            if ($urandom_range(0, 2) != 0) set_req(i, 1'($urandom), a, DW'($urandom));
        end
    endtask

    task automatic sweep_with_noise();
        for (int n = 0; n < NSWP; n++) begin
            rand_req(1'b0);
            tick();
        end
        idle();
    endtask

    initial begin
        RST = 1'b1;
        idle();
        repeat (3) tick();
        RST = 1'b0;
        sweep_with_noise();

        // All four reading from p = 0: pairs {0,1}, {2,3}, then back to {0,1}.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'($urandom), '0);
        @(negedge CLK); chk(req_ready == 4'b0011, "rr_pair01", req_ready, 4'b0011);
        tick();
        @(negedge CLK); chk(req_ready == 4'b1100, "rr_pair23", req_ready, 4'b1100);
        tick();
        @(negedge CLK); chk(req_ready == 4'b0011, "rr_wrap", req_ready, 4'b0011);
        tick();
        idle();
        tick();

        // Write then read-back through a different requester.
        set_req(0, 1'b1, 10'h155, 16'hBEEF);
        tick();
        idle();
        set_req(2, 1'b0, 10'h155, '0);
        tick();
        idle();
        @(negedge CLK);
        chk(rsp_valid == 4'b0100 && rsp_data[2*DW +: DW] == 16'hBEEF, "readback",
            {rsp_valid, rsp_data[2*DW +: DW]}, {4'b0100, 16'hBEEF});
        tick();

        // Pointer to 1, then a same-address write/read collision.
        set_req(0, 1'b0, 10'h001, '0);
        tick();
        idle();
        set_req(1, 1'b1, 10'h3FF, 16'h1234);
        set_req(3, 1'b0, 10'h3FF, '0);
        @(negedge CLK); chk(req_ready == 4'b0010, "collision_stall", req_ready, 4'b0010);
        tick();
        idle();
        set_req(3, 1'b0, 10'h3FF, '0);
        @(negedge CLK); chk(req_ready == 4'b1000, "collision_retry", req_ready, 4'b1000);
        tick();
        idle();
        @(negedge CLK);
        chk(rsp_valid == 4'b1000 && rsp_data[3*DW +: DW] == 16'h1234, "collision_data",
            {rsp_valid, rsp_data[3*DW +: DW]}, {4'b1000, 16'h1234});
        tick();

        // Reset right after a read grant drops the response.
        set_req(0, 1'b0, 10'h155, '0);
        tick();
        idle();
        RST = 1'b1;
        @(negedge CLK); chk(rsp_valid == '0, "reset_drops_rsp", rsp_valid, 0);
        tick();
        RST = 1'b0;
        sweep_with_noise();

        // Lone requester 3 owns port 0 every cycle; port 1 stays idle.
        for (int n = 0; n < 5; n++) begin
            idle();
            set_req(3, 1'b0, AW'($urandom), '0);
            @(negedge CLK);
            chk(req_ready == 4'b1000 && ce0 && !ce1, "lone_req3", {req_ready, ce0, ce1}, {4'b1000, 2'b10});
            tick();
        end

        // Randomized traffic, alternating narrow (collision-heavy) and wide addressing.
        for (int n = 0; n < 3000; n++) begin
            rand_req(n % 500 < 300);
            tick();
        end
        idle();
        repeat (3) tick();
        for (int i = 0; i < NREQ; i++) chk(exp_q[i].size() == 0, "drain", exp_q[i].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
